// File: rtl/fifo.sv
// Synchronous single-clock FIFO of DEPTH words, each DATA_WIDTH bits wide.
// Latency: a write is readable from the next edge; read data is registered and appears one edge after read_en.
// Backpressure: writes while full and reads while empty are silently dropped; full/empty are decoded from the registered count.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst      - asynchronous active-low reset (clears pointers, count and data_out)
//   write_en - write request; accepted when !full
//   read_en  - read request; accepted when !empty
//   data_in  - word stored on an accepted write
//   data_out - registered read data; holds its value when no read is accepted
//   full     - FIFO holds DEPTH words
//   empty    - FIFO holds 0 words
module fifo #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q,  count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    logic wr_ok;
    logic rd_ok;

    // Flags come straight from the registered count, so they change only on clk.
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // Acceptance uses the pre-edge flags: when empty only a write can land
    // (no fall-through), when full only a read can land.
    assign wr_ok = write_en && !full;
    assign rd_ok = read_en  && !empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;

        if (wr_ok) begin
            // Explicit wrap so non-power-of-two depths work.
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end

        if (rd_ok) begin
            data_out_d = mem_q[rd_ptr_q];
            rd_ptr_d   = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        // Simultaneous accepted read and write leave occupancy unchanged.
        if (wr_ok && !rd_ok) begin
            count_d = count_q + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is deliberately left out of reset; stale words are unreachable
    // because the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_fifo.sv
module tb_fifo;

    localparam int DEPTH = 8;
    localparam int DW    = 16;

    logic          clk;
    logic          rst;
    logic          write_en;
    logic          read_en;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;

    int n_chk;
    int n_err;

    // Reference model: a plain queue of accepted words plus the last read word.
    logic [DW-1:0] ref_q [$];
    logic [DW-1:0] ref_dout;

    fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .write_en (write_en),
        .read_en  (read_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".dout"},  32'(data_out), 32'(ref_dout));
        chk({tag, ".full"},  32'(full),     32'(ref_q.size() == DEPTH));
        chk({tag, ".empty"}, 32'(empty),    32'(ref_q.size() == 0));
    endtask

    // Called at a falling edge; applies one cycle of stimulus, updates the
    // model at the rising edge, checks 1 ns later, returns at the next falling edge.
    task automatic step(input logic we, input logic re, input logic [DW-1:0] din, input string tag);
        bit acc_w;
        bit acc_r;
        write_en = we;
        read_en  = re;
        data_in  = din;
        acc_w = we && (ref_q.size() < DEPTH);
        acc_r = re && (ref_q.size() > 0);
        @(posedge clk);
        if (acc_r) ref_dout = ref_q.pop_front();
        if (acc_w) ref_q.push_back(din);
        #1;
        chk_state(tag);
        @(negedge clk);
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        ref_dout = '0;
        write_en = 1'b0;
        read_en  = 1'b0;
        data_in  = '0;
        rst      = 1'b0;

        // 1. reset held for two cycles
        repeat (2) @(negedge clk);
        chk("rst.empty", 32'(empty),    32'd1);
        chk("rst.full",  32'(full),     32'd0);
        chk("rst.dout",  32'(data_out), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        step(1'b0, 1'b1, 16'h0, "rd_empty");
        chk("rd_empty.dout0", 32'(data_out), 32'h0);

        // 2. fill with 1111..8888
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, 16'(i * 16'h1111), "fill");
            if (i == 1)     chk("fill.first_empty", 32'(empty), 32'd0);
            if (i == DEPTH) chk("fill.last_full",   32'(full),  32'd1);
        end

        // 3. overflow write is dropped
        step(1'b1, 1'b0, 16'hBEEF, "ovf");
        chk("ovf.full", 32'(full), 32'd1);

        // 4. drain in order, then one extra read
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, 1'b1, 16'h0, "drain");
            chk("drain.val", 32'(data_out), 32'(i * 16'h1111));
        end
        chk("drain.empty", 32'(empty), 32'd1);
        step(1'b0, 1'b1, 16'h0, "rd9");
        chk("rd9.hold", 32'(data_out), 32'h8888);

        // 5. wrap-around: 5 in, 5 out, then 8 in / 8 out across the wrap
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'(16'hA000 + i), "wrap_w5");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h0, "wrap_r5");
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 16'(16'hC000 + i), "wrap_w8");
        chk("wrap.full", 32'(full), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 16'h0, "wrap_r8");
            chk("wrap.val", 32'(data_out), 32'(16'hC000 + i));
        end

        // 6a. simultaneous at occupancy 3
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'(16'h3000 + i), "occ3_w");
        step(1'b1, 1'b1, 16'h3003, "occ3_rw");
        chk("occ3.oldest", 32'(data_out), 32'h3000);
        for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 16'h0, "occ3_r");
        chk("occ3.cnt3_empty", 32'(empty), 32'd1);

        // 6b. simultaneous at empty: write only, no fall-through
        step(1'b1, 1'b1, 16'h5A5A, "emp_rw");
        chk("emp_rw.dout", 32'(data_out), 32'h3003);
        chk("emp_rw.empty", 32'(empty), 32'd0);
        step(1'b0, 1'b1, 16'h0, "emp_rd");
        chk("emp_rd.val", 32'(data_out), 32'h5A5A);

        // 6c. simultaneous at full: read only
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 16'(16'h7000 + i), "full_w");
        step(1'b1, 1'b1, 16'hDEAD, "full_rw");
        chk("full_rw.dout", 32'(data_out), 32'h7000);
        chk("full_rw.full", 32'(full), 32'd0);
        for (int i = 1; i < DEPTH; i++) step(1'b0, 1'b1, 16'h0, "full_r");
        chk("full_r.last", 32'(data_out), 32'h7007);
        chk("full_r.empty", 32'(empty), 32'd1);

        // 6d. random traffic against the queue model
        for (int i = 0; i < 20; i++) begin
            step(1'($urandom), 1'($urandom), 16'($urandom), "rand");
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'($urandom), "pre_rst");

        // 6e. asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        ref_q.delete();
        ref_dout = '0;
        chk("arst.empty", 32'(empty),    32'd1);
        chk("arst.full",  32'(full),     32'd0);
        chk("arst.dout",  32'(data_out), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b1, 16'h0, "arst_rd");
        step(1'b1, 1'b0, 16'h1234, "arst_w");
        step(1'b0, 1'b1, 16'h0, "arst_r");
        chk("arst.after", 32'(data_out), 32'h1234);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
